// File: rtl/pinball_pkg.sv
// Shared pinball types and constants: flipper FSM states, length-shift decode, default colours.
package pinball_pkg;

    typedef enum logic [1:0] {
        StRest,
        StRising,
        StHeld,
        StFalling
    } flip_state_e;

    // Flipper length as a shift amount (length = 2^LSH pixels)
    localparam logic [2:0] LSH_WIDE   = 3'd6;
    localparam logic [2:0] LSH_MID    = 3'd5;
    localparam logic [2:0] LSH_NARROW = 3'd4;

    localparam logic [7:0] DEFAULT_REST_RGB = 8'b00011100;
    localparam logic [7:0] DEFAULT_KICK_RGB = 8'b11111100;

    // Higher score digit -> shorter flippers
    function automatic logic [2:0] lsh_decode(input logic [3:0] digit);
        if (digit == 4'd0) begin
            return LSH_WIDE;
        end else if (digit <= 4'd2) begin
            return LSH_MID;
        end
        return LSH_NARROW;
    endfunction

endpackage

// File: rtl/flipper_side.sv
// One flipper: press latch, swing FSM, tip lift and per-pixel hit test.
module flipper_side
    import pinball_pkg::*;
#(
    parameter bit MIRROR    = 1'b0,
    parameter int PIVOT_X   = 248,
    parameter int BASE_Y    = 388,
    parameter int THICK     = 8,
    parameter int LIFT_MAX  = 24,
    parameter int UP_STEP   = 6,
    parameter int DOWN_STEP = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        press,
    input  logic [2:0]  lsh,
    output logic        drawReq,
    output logic        kick,
    output logic [5:0]  lift
);

    localparam logic [6:0]  MAX7  = 7'(LIFT_MAX);
    localparam logic [6:0]  UP7   = 7'(UP_STEP);
    localparam logic [6:0]  DOWN7 = 7'(DOWN_STEP);
    localparam logic [12:0] PIV13 = 13'(PIVOT_X);
    localparam logic [12:0] Y_TOP = 13'(BASE_Y);
    localparam logic [12:0] Y_END = 13'(BASE_Y + THICK);

    flip_state_e state_q, state_d;
    logic [5:0]  lift_q, lift_d;
    logic        flag_q, flag_d;
    logic        pressed;
    logic [6:0]  lift_up, lift_dn;

    // A press on the frame-boundary cycle itself still counts for that frame
    assign pressed = flag_q | press;

    // Saturating lift arithmetic in 7 bits so neither direction can wrap
    always_comb begin
        lift_up = {1'b0, lift_q} + UP7;
        if (lift_up > MAX7) begin
            lift_up = MAX7;
        end
        lift_dn = ({1'b0, lift_q} > DOWN7) ? ({1'b0, lift_q} - DOWN7) : 7'd0;
    end

    // Next-state: flag accumulates presses, FSM and lift move only on frame start
    always_comb begin
        state_d = state_q;
        lift_d  = lift_q;
        flag_d  = flag_q | press;
        if (startOfFrame) begin
            flag_d = 1'b0;
            case (state_q)
                StRest: begin
                    if (pressed) begin
                        state_d = StRising;
                        lift_d  = lift_up[5:0];
                    end
                end
                StRising: begin
                    if (pressed) begin
                        lift_d = lift_up[5:0];
                        if (lift_up == MAX7) begin
                            state_d = StHeld;
                        end
                    end else begin
                        state_d = StFalling;
                        lift_d  = lift_dn[5:0];
                    end
                end
                StHeld: begin
                    if (!pressed) begin
                        state_d = StFalling;
                        lift_d  = lift_dn[5:0];
                    end
                end
                StFalling: begin
                    if (pressed) begin
                        state_d = StRising;
                        lift_d  = lift_up[5:0];
                    end else begin
                        lift_d = lift_dn[5:0];
                        if (lift_dn == 7'd0) begin
                            state_d = StRest;
                        end
                    end
                end
                default: begin
                    state_d = StRest;
                    lift_d  = 6'd0;
                end
            endcase
        end
    end

    // State register; reset drops the flipper to rest and forgets any pending press
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= StRest;
            lift_q  <= 6'd0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lift_q  <= lift_d;
            flag_q  <= flag_d;
        end
    end

    assign kick = (state_q == StRising);
    assign lift = lift_q;

    logic [12:0] dx;
    logic        in_range;
    logic [11:0] prod;
    logic [11:0] off;
    logic [12:0] y_plus;

    // Hit test: distance from pivot along the flipper, tip raised in proportion to it
    always_comb begin
        if (MIRROR) begin
            dx = PIV13 - {2'b00, pixelX};
        end else begin
            dx = {2'b00, pixelX} - PIV13;
        end
        in_range = !dx[12] && ((dx[11:0] >> lsh) == 12'd0);
        prod     = 12'(lift_q) * 12'(dx[5:0]);
        off      = prod >> lsh;
        // pixelY + off compared against the rest rows avoids a negative top row
        y_plus   = {2'b00, pixelY} + {1'b0, off};
        drawReq  = in_range && (y_plus >= Y_TOP) && (y_plus < Y_END);
    end

endmodule

// File: rtl/flipper_bank.sv
// Left/right flipper pair with difficulty-scaled length and shared colour mux.
module flipper_bank
    import pinball_pkg::*;
#(
    parameter int         CENTER_X  = 320,
    parameter int         PIVOT_DX  = 72,
    parameter int         BASE_Y    = 388,
    parameter int         THICK     = 8,
    parameter int         LIFT_MAX  = 24,
    parameter int         UP_STEP   = 6,
    parameter int         DOWN_STEP = 2,
    parameter logic [7:0] REST_RGB  = DEFAULT_REST_RGB,
    parameter logic [7:0] KICK_RGB  = DEFAULT_KICK_RGB
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        leftPress,
    input  logic        rightPress,
    input  logic [3:0]  ScoreDig4,
    output logic        leftDrawReq,
    output logic        rightDrawReq,
    output logic        flipperDrawReq,
    output logic [7:0]  Flipper_RGB,
    output logic        leftKick,
    output logic        rightKick,
    output logic [5:0]  leftLift,
    output logic [5:0]  rightLift
);

    logic [2:0] lsh_q;

    // Length latched once per frame so a score change never reshapes a frame mid-scan
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lsh_q <= LSH_WIDE;
        end else if (startOfFrame) begin
            lsh_q <= lsh_decode(ScoreDig4);
        end
    end

    flipper_side #(
        .MIRROR    (1'b0),
        .PIVOT_X   (CENTER_X - PIVOT_DX),
        .BASE_Y    (BASE_Y),
        .THICK     (THICK),
        .LIFT_MAX  (LIFT_MAX),
        .UP_STEP   (UP_STEP),
        .DOWN_STEP (DOWN_STEP)
    ) u_left (
        .clk          (clk),
        .resetN       (resetN),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .startOfFrame (startOfFrame),
        .press        (leftPress),
        .lsh          (lsh_q),
        .drawReq      (leftDrawReq),
        .kick         (leftKick),
        .lift         (leftLift)
    );

    flipper_side #(
        .MIRROR    (1'b1),
        .PIVOT_X   (CENTER_X + PIVOT_DX),
        .BASE_Y    (BASE_Y),
        .THICK     (THICK),
        .LIFT_MAX  (LIFT_MAX),
        .UP_STEP   (UP_STEP),
        .DOWN_STEP (DOWN_STEP)
    ) u_right (
        .clk          (clk),
        .resetN       (resetN),
        .pixelX       (pixelX),
        .pixelY       (pixelY),
        .startOfFrame (startOfFrame),
        .press        (rightPress),
        .lsh          (lsh_q),
        .drawReq      (rightDrawReq),
        .kick         (rightKick),
        .lift         (rightLift)
    );

    // Colour follows the hitting side; left wins an overlap
    always_comb begin
        flipperDrawReq = leftDrawReq | rightDrawReq;
        Flipper_RGB    = REST_RGB;
        if (leftDrawReq) begin
            Flipper_RGB = leftKick ? KICK_RGB : REST_RGB;
        end else if (rightDrawReq && rightKick) begin
            Flipper_RGB = KICK_RGB;
        end
    end

endmodule

// File: tb/tb_flipper_bank.sv
// Randomised scoreboard bench for flipper_bank against a frame-level reference model.
module tb_flipper_bank;

    localparam int CX   = 320;
    localparam int PDX  = 72;
    localparam int BY   = 388;
    localparam int TH   = 8;
    localparam int LMAX = 24;
    localparam int UP   = 6;
    localparam int DN   = 2;
    localparam int XL   = CX - PDX;
    localparam int XR   = CX + PDX;
    localparam logic [7:0] C_REST = 8'b00011100;
    localparam logic [7:0] C_KICK = 8'b11111100;

    localparam int M_REST = 0;
    localparam int M_RISE = 1;
    localparam int M_HELD = 2;
    localparam int M_FALL = 3;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        startOfFrame = 1'b0;
    logic        leftPress = 1'b0;
    logic        rightPress = 1'b0;
    logic [3:0]  ScoreDig4 = '0;
    logic        leftDrawReq, rightDrawReq, flipperDrawReq;
    logic [7:0]  Flipper_RGB;
    logic        leftKick, rightKick;
    logic [5:0]  leftLift, rightLift;

    flipper_bank dut (
        .clk            (clk),
        .resetN         (resetN),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .startOfFrame   (startOfFrame),
        .leftPress      (leftPress),
        .rightPress     (rightPress),
        .ScoreDig4      (ScoreDig4),
        .leftDrawReq    (leftDrawReq),
        .rightDrawReq   (rightDrawReq),
        .flipperDrawReq (flipperDrawReq),
        .Flipper_RGB    (Flipper_RGB),
        .leftKick       (leftKick),
        .rightKick      (rightKick),
        .leftLift       (leftLift),
        .rightLift      (rightLift)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int lift;
    } side_t;

    typedef struct packed {
        logic [5:0] ll;
        logic [5:0] rl;
        logic       lk;
        logic       rk;
    } fexp_t;

    typedef struct packed {
        logic       l;
        logic       r;
        logic [7:0] rgb;
    } dexp_t;

    fexp_t fq[$];
    dexp_t dq[$];

    side_t ml, mr;
    int    mlsh;
    bit    lseen, rseen;
    bit    obs_frame = 1'b0;
    bit    obs_draw = 1'b0;
    int    n_checks = 0;
    int    n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: one frame step of a flipper from the textual swing rules
    function automatic side_t step(input side_t s, input bit p);
        side_t n;
        int    up;
        int    dn;
        n  = s;
        up = (s.lift + UP > LMAX) ? LMAX : s.lift + UP;
        dn = (s.lift - DN < 0) ? 0 : s.lift - DN;
        case (s.st)
            M_REST: if (p) begin n.st = M_RISE; n.lift = up; end
            M_RISE: begin
                if (p) begin
                    n.lift = up;
                    if (up == LMAX) n.st = M_HELD;
                end else begin
                    n.st = M_FALL; n.lift = dn;
                end
            end
            M_HELD: if (!p) begin n.st = M_FALL; n.lift = dn; end
            default: begin
                if (p) begin
                    n.st = M_RISE; n.lift = up;
                end else begin
                    n.lift = dn;
                    if (dn == 0) n.st = M_REST;
                end
            end
        endcase
        return n;
    endfunction

    function automatic int dig_to_lsh(input int d);
        if (d == 0) return 6;
        if (d <= 2) return 5;
        return 4;
    endfunction

    function automatic bit hit_m(input int pivot, input bit mirror, input int lift,
                                 input int lsh, input int x, input int y);
        int dx;
        int off;
        dx = mirror ? pivot - x : x - pivot;
        if (dx < 0 || dx >= (1 << lsh)) return 1'b0;
        off = (lift * dx) >> lsh;
        return (y >= BY - off) && (y < BY - off + TH);
    endfunction

    // Monitor: compares DUT outputs whenever the driver marks a cycle as observable
    always @(negedge clk) begin
        if (obs_frame) begin
            if (fq.size() == 0) begin
                chk("frame_queue_underflow", 1, 0);
            end else begin
                fexp_t e;
                e = fq.pop_front();
                chk("leftLift", int'(leftLift), int'(e.ll));
                chk("rightLift", int'(rightLift), int'(e.rl));
                chk("leftKick", int'(leftKick), int'(e.lk));
                chk("rightKick", int'(rightKick), int'(e.rk));
            end
        end
        if (obs_draw) begin
            if (dq.size() == 0) begin
                chk("draw_queue_underflow", 1, 0);
            end else begin
                dexp_t d;
                d = dq.pop_front();
                chk("leftDrawReq", int'(leftDrawReq), int'(d.l));
                chk("rightDrawReq", int'(rightDrawReq), int'(d.r));
                chk("flipperDrawReq", int'(flipperDrawReq), int'(d.l | d.r));
                if (d.l || d.r) chk("Flipper_RGB", int'(Flipper_RGB), int'(d.rgb));
            end
        end
    end

    function automatic fexp_t model_state();
        fexp_t e;
        e.ll = 6'(ml.lift);
        e.rl = 6'(mr.lift);
        e.lk = (ml.st == M_RISE);
        e.rk = (mr.st == M_RISE);
        return e;
    endfunction

    task automatic cyc(input bit l, input bit r);
        leftPress  = l;
        rightPress = r;
        lseen |= l;
        rseen |= r;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input bit l, input bit r);
        leftPress    = l;
        rightPress   = r;
        startOfFrame = 1'b1;
        lseen |= l;
        rseen |= r;
        ml   = step(ml, lseen);
        mr   = step(mr, rseen);
        mlsh = dig_to_lsh(int'(ScoreDig4));
        lseen = 1'b0;
        rseen = 1'b0;
        fq.push_back(model_state());
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        leftPress    = 1'b0;
        rightPress   = 1'b0;
        obs_frame    = 1'b1;
        @(posedge clk);
        #1;
        obs_frame = 1'b0;
    endtask

    task automatic probe(input int x, input int y);
        dexp_t d;
        pixelX = 11'(x);
        pixelY = 11'(y);
        lseen |= leftPress;
        rseen |= rightPress;
        d.l = hit_m(XL, 1'b0, ml.lift, mlsh, x, y);
        d.r = hit_m(XR, 1'b1, mr.lift, mlsh, x, y);
        if (d.l) d.rgb = (ml.st == M_RISE) ? C_KICK : C_REST;
        else     d.rgb = (mr.st == M_RISE) ? C_KICK : C_REST;
        dq.push_back(d);
        obs_draw = 1'b1;
        @(posedge clk);
        #1;
        obs_draw = 1'b0;
    endtask

    task automatic do_reset();
        leftPress    = 1'b0;
        rightPress   = 1'b0;
        startOfFrame = 1'b0;
        resetN       = 1'b0;
        ml.st = M_REST; ml.lift = 0;
        mr.st = M_REST; mr.lift = 0;
        mlsh  = 6;
        lseen = 1'b0;
        rseen = 1'b0;
        fq.push_back(model_state());
        obs_frame = 1'b1;
        @(negedge clk);
        #1;
        obs_frame = 1'b0;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        do_reset();
        ScoreDig4 = 4'd0;

        // Held left press: 6,12,18,24 then held
        for (int f = 0; f < 5; f++) begin
            cyc(1'b1, 1'b0);
            frame(1'b1, 1'b0);
        end
        // Release: 22 down to 0 over 12 frames
        for (int f = 0; f < 12; f++) begin
            cyc(1'b0, 1'b0);
            frame(1'b0, 1'b0);
        end
        // Single-cycle right pulse mid-frame
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        frame(1'b0, 1'b0);
        for (int f = 0; f < 4; f++) frame(1'b0, 1'b0);

        // Geometry at full length, lift 24
        for (int f = 0; f < 4; f++) frame(1'b1, 1'b0);
        probe(XL + 32, 376);
        probe(XL + 32, 375);
        probe(XL + 32, 383);
        probe(XL + 32, 384);
        probe(XL + 63, 366);
        probe(XL + 64, 388);
        probe(XL - 1, 388);
        probe(XR, 388);
        probe(XR - 40, 388);
        // Short flippers: dx 32 out of range
        ScoreDig4 = 4'd3;
        frame(1'b1, 1'b0);
        probe(XL + 32, 376);
        probe(XL + 8, 376);
        probe(XL + 16, 364);
        probe(XL + 15, 365);

        // Falling to 10, re-press, then reset mid-swing
        for (int f = 0; f < 7; f++) frame(1'b0, 1'b0);
        frame(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        do_reset();
        probe(XL + 5, 388);
        frame(1'b0, 1'b0);

        // Random traffic
        for (int f = 0; f < 300; f++) begin
            int ncyc;
            int lb;
            int rb;
            if ($urandom_range(0, 7) == 0) ScoreDig4 = 4'($urandom_range(0, 9));
            ncyc = $urandom_range(1, 5);
            lb   = $urandom_range(0, 4);
            rb   = $urandom_range(0, 4);
            for (int c = 0; c < ncyc; c++) begin
                cyc(($urandom_range(0, 3) < lb), ($urandom_range(0, 3) < rb));
            end
            for (int p = 0; p < 2; p++) begin
                int dx;
                int y;
                dx = $urandom_range(0, 70) - 3;
                y  = 355 + $urandom_range(0, 45);
                if ($urandom_range(0, 1) == 1) probe(XR - dx, y);
                else probe(XL + dx, y);
            end
            if ($urandom_range(0, 59) == 0) do_reset();
            else frame(($urandom_range(0, 3) < lb), ($urandom_range(0, 3) < rb));
        end

        repeat (3) @(posedge clk);
        chk("frame_queue_drained", fq.size(), 0);
        chk("draw_queue_drained", dq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
